prog_sequencer: RTL and testbench

//   Program-memory instruction source for the 4-bit ALU core: the store-and-issue
//   end of the instruction path that the switch fetch stage consumes.

---
 rtl/prog_sequencer.sv | 176 +++++++++++++++++
 tb/tb_prog_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program RAM loader and FETCH/DEC/ALU/WRI instruction issuer; single-step build via PROG_SEQ_STEP_EN
module prog_sequencer #(
    parameter int ADDR_W    = 4,
    parameter int PHASE_CYC = 16,
    parameter int DEB_CYC   = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_START,
    input  logic              SW_LOAD,
    input  logic [7:0]        SW_INST,
    output logic [7:0]        INST,
    output logic              DEC_EN,
    output logic              ALU_EN,
    output logic              WRI_EN,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W:0]   PLEN,
    output logic              BUSY,
    output logic              FULL
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PH_W  = $clog2(PHASE_CYC);
    localparam int DEB_W = $clog2(DEB_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DEC,
        S_ALU,
        S_WRI
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    plen_q, plen_d;
    logic [7:0]         inst_q, inst_d;
    logic [PH_W-1:0]    ph_q, ph_d;

    logic               sync1_q, sync2_q;
    logic               deb_q, deb_prev_q;
    logic [DEB_W-1:0]   deb_cnt_q;
    logic               press;

    logic [7:0]         mem [DEPTH];
    logic               mem_we;
    logic               phase_last;
    logic               last_inst;
    logic               full;

    // Button path: two-stage synchroniser, stability counter, then rising-edge detect.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            sync1_q    <= SW_START;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign press      = deb_q & ~deb_prev_q;
    assign full       = (plen_q == (ADDR_W + 1)'(DEPTH));
    assign phase_last = (ph_q == PH_W'(PHASE_CYC - 1));
    assign last_inst  = ({1'b0, pc_q} == plen_q - (ADDR_W + 1)'(1));

    // Program RAM write port; contents survive reset and are qualified by PLEN.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[plen_q[ADDR_W-1:0]] <= SW_INST;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            plen_q  <= '0;
            inst_q  <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            plen_q  <= plen_d;
            inst_q  <= inst_d;
            ph_q    <= ph_d;
        end
    end

    // Next-state, program counter, length and instruction latch decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        plen_d  = plen_q;
        inst_d  = inst_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    if (SW_LOAD) begin
                        if (!full) begin
                            mem_we = !RST;
                            plen_d = plen_q + (ADDR_W + 1)'(1);
                        end
                    end else if (plen_q != '0) begin
                        state_d = S_FETCH;
`ifndef PROG_SEQ_STEP_EN
                        pc_d    = '0;
`endif
                    end
                end
            end
            S_FETCH: begin
                if (ph_q == '0) begin
                    inst_d = mem[pc_q];
                end
                if (phase_last) begin
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (phase_last) begin
                    state_d = S_ALU;
                end
            end
            S_ALU: begin
                if (phase_last) begin
                    state_d = S_WRI;
                end
            end
            S_WRI: begin
                if (phase_last) begin
                    pc_d = last_inst ? '0 : pc_q + ADDR_W'(1);
`ifdef PROG_SEQ_STEP_EN
                    state_d = S_IDLE;
`else
                    state_d = last_inst ? S_IDLE : S_FETCH;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Phase counter restarts on every state entry and wraps within a phase.
        if (state_d != state_q || phase_last || state_q == S_IDLE) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + PH_W'(1);
        end
    end

    // Outputs: phase strobes on the first cycle of each phase, suppressed while in reset.
    always_comb begin
        DEC_EN = !RST && (state_q == S_DEC) && (ph_q == '0);
        ALU_EN = !RST && (state_q == S_ALU) && (ph_q == '0);
        WRI_EN = !RST && (state_q == S_WRI) && (ph_q == '0);
        BUSY   = (state_q != S_IDLE);
        FULL   = full;
        INST   = inst_q;
        PC     = pc_q;
        PLEN   = plen_q;
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - randomized self-checking bench for prog_sequencer against a queue-based program model
module tb_prog_sequencer;

    localparam int AW    = 4;
    localparam int P     = 4;
    localparam int DEB   = 16;
    localparam int DEPTH = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          SW_START;
    logic          SW_LOAD;
    logic [7:0]    SW_INST;
    logic [7:0]    INST;
    logic          DEC_EN;
    logic          ALU_EN;
    logic          WRI_EN;
    logic [AW-1:0] PC;
    logic [AW:0]   PLEN;
    logic          BUSY;
    logic          FULL;

    logic [7:0] prog[$];
    int         pc_m;
    int         checks = 0;
    int         errors = 0;

    prog_sequencer #(.ADDR_W(AW), .PHASE_CYC(P), .DEB_CYC(DEB)) dut (
        .CLK(CLK), .RST(RST), .SW_START(SW_START), .SW_LOAD(SW_LOAD), .SW_INST(SW_INST),
        .INST(INST), .DEC_EN(DEC_EN), .ALU_EN(ALU_EN), .WRI_EN(WRI_EN),
        .PC(PC), .PLEN(PLEN), .BUSY(BUSY), .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; SW_START = 1'b0; SW_LOAD = 1'b0; SW_INST = 8'h00;
        repeat (3) tick();
        checks++;
        if (PC !== '0 || PLEN !== '0 || INST !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: PC=%0h PLEN=%0h INST=%0h expected 0/0/0", PC, PLEN, INST);
        end
        checks++;
        if (BUSY !== 1'b0 || FULL !== 1'b0 || {DEC_EN, ALU_EN, WRI_EN} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: BUSY=%b FULL=%b strobes=%b expected 0/0/000", BUSY, FULL, {DEC_EN, ALU_EN, WRI_EN});
        end
        RST = 1'b0;
        tick();
        prog.delete();
        pc_m = 0;
    endtask

    task automatic test_run_empty();
        int busy_cnt;
        busy_cnt = 0;
        SW_LOAD = 1'b0; SW_START = 1'b1;
        for (int c = 1; c <= 2 * DEB + 20; c++) begin
            tick();
            if (c == DEB + 6) SW_START = 1'b0;
            if (BUSY !== 1'b0) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL empty_run_busy: busy cycles=%0d expected 0", busy_cnt);
        end
        checks++;
        if (PLEN !== '0) begin
            errors++;
            $display("FAIL empty_run_plen: PLEN=%0d expected 0", PLEN);
        end
    endtask

    task automatic load_word(input logic [7:0] w, input bit bouncy);
        SW_LOAD = 1'b1; SW_INST = w;
        if (bouncy) begin
            repeat (5) begin
                SW_START = 1'b1;
                repeat ($urandom_range(1, DEB - 4)) tick();
                SW_START = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        SW_START = 1'b1;
        repeat (DEB + 6) tick();
        SW_START = 1'b0;
        repeat (DEB + 6) tick();
        if (prog.size() < DEPTH) prog.push_back(w);
        checks++;
        if (PLEN !== (AW + 1)'(prog.size())) begin
            errors++;
            $display("FAIL load_plen: word=%02h PLEN=%0d expected %0d", w, PLEN, prog.size());
        end
        checks++;
        if (FULL !== (prog.size() == DEPTH)) begin
            errors++;
            $display("FAIL load_full: word=%02h FULL=%b expected %b", w, FULL, prog.size() == DEPTH);
        end
        SW_LOAD = 1'b0;
    endtask

    task automatic run_once(input bit disturb);
        int n, first, c, t0, busy_len, budget, inst_bad, exp_pc_after, plen_before, slot;
        bit ended;
        int dec_t[$];
        int alu_t[$];
        int wri_t[$];
        int dec_pc[$];
        logic [7:0] dec_inst[$];
`ifdef PROG_SEQ_STEP_EN
        n = 1; first = pc_m; exp_pc_after = (pc_m + 1) % prog.size();
`else
        n = prog.size(); first = 0; exp_pc_after = 0;
`endif
        plen_before = prog.size();
        budget = 4 * DEB + 60 + n * 4 * P + 200;
        t0 = -1; busy_len = 0; ended = 0; inst_bad = 0; c = 0;
        SW_LOAD = 1'b0; SW_START = 1'b1;
        while (c < budget && !(ended && c >= 4 * DEB + 30)) begin
            tick();
            c++;
            if (c == DEB + 6) SW_START = 1'b0;
            if (disturb) begin
                if (t0 >= 0 && c == t0 + 3) begin
                    SW_LOAD = 1'b1;
                    SW_INST = 8'($urandom_range(0, 255));
                end
`ifdef PROG_SEQ_STEP_EN
                if (t0 >= 0 && c == t0 + 10) SW_LOAD = 1'b0;
`else
                if (c == 2 * DEB + 12) SW_START = 1'b1;
                if (c == 3 * DEB + 18) SW_START = 1'b0;
                if (t0 >= 0 && c == t0 + 120) SW_LOAD = 1'b0;
`endif
            end
            if (BUSY === 1'b1) begin
                if (t0 < 0) t0 = c;
                busy_len++;
                slot = (c - t0) / (4 * P);
                if ((c - t0) % (4 * P) != 0 && slot < n && INST !== prog[first + slot]) inst_bad++;
            end else if (t0 >= 0) begin
                ended = 1;
            end
            if (DEC_EN === 1'b1) begin
                dec_t.push_back(c); dec_inst.push_back(INST); dec_pc.push_back(int'(PC));
            end
            if (ALU_EN === 1'b1) alu_t.push_back(c);
            if (WRI_EN === 1'b1) wri_t.push_back(c);
        end
        SW_LOAD = 1'b0; SW_START = 1'b0;
        checks++;
        if (t0 < DEB || t0 > DEB + 3) begin
            errors++;
            $display("FAIL run_start_latency: BUSY rose at cycle %0d expected %0d..%0d", t0, DEB, DEB + 3);
        end
        checks++;
        if (busy_len != n * 4 * P) begin
            errors++;
            $display("FAIL run_busy_len: %0d cycles expected %0d", busy_len, n * 4 * P);
        end
        checks++;
        if (dec_t.size() != n || alu_t.size() != n || wri_t.size() != n) begin
            errors++;
            $display("FAIL run_strobe_count: dec=%0d alu=%0d wri=%0d expected %0d each",
                     dec_t.size(), alu_t.size(), wri_t.size(), n);
        end
        for (int k = 0; k < n; k++) begin
            if (k < dec_t.size()) begin
                checks++;
                if (dec_t[k] - t0 != 4 * P * k + P) begin
                    errors++;
                    $display("FAIL run_dec_offset: instr %0d at %0d expected %0d", k, dec_t[k] - t0, 4 * P * k + P);
                end
                checks++;
                if (dec_inst[k] !== prog[first + k] || dec_pc[k] != first + k) begin
                    errors++;
                    $display("FAIL run_inst: instr %0d INST=%02h PC=%0d expected %02h/%0d",
                             k, dec_inst[k], dec_pc[k], prog[first + k], first + k);
                end
            end
            if (k < alu_t.size()) begin
                checks++;
                if (alu_t[k] - t0 != 4 * P * k + 2 * P) begin
                    errors++;
                    $display("FAIL run_alu_offset: instr %0d at %0d expected %0d", k, alu_t[k] - t0, 4 * P * k + 2 * P);
                end
            end
            if (k < wri_t.size()) begin
                checks++;
                if (wri_t[k] - t0 != 4 * P * k + 3 * P) begin
                    errors++;
                    $display("FAIL run_wri_offset: instr %0d at %0d expected %0d", k, wri_t[k] - t0, 4 * P * k + 3 * P);
                end
            end
        end
        checks++;
        if (inst_bad != 0) begin
            errors++;
            $display("FAIL run_inst_stable: %0d cycles with wrong INST expected 0", inst_bad);
        end
        checks++;
        if (PC !== AW'(exp_pc_after) || PLEN !== (AW + 1)'(plen_before)) begin
            errors++;
            $display("FAIL run_end_state: PC=%0d PLEN=%0d expected %0d/%0d", PC, PLEN, exp_pc_after, plen_before);
        end
        pc_m = exp_pc_after;
    endtask

    task automatic run_program(input bit disturb);
`ifdef PROG_SEQ_STEP_EN
        int n;
        n = prog.size();
        for (int i = 0; i < n; i++) run_once(disturb && i == 0);
`else
        run_once(disturb);
`endif
    endtask

    task automatic test_load();
        load_word(8'h15, 1'b0);
        load_word(8'h23, 1'b1);
        load_word(8'h40, 1'b0);
    endtask

    task automatic test_run();
`ifdef PROG_SEQ_STEP_EN
        repeat (4) run_once(1'b0);
`else
        run_once(1'b0);
`endif
    endtask

    task automatic test_full();
        while (prog.size() < DEPTH) load_word(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        load_word(8'hAA, 1'b0);
        run_program(1'b1);
    endtask

    task automatic test_reset_midrun();
        bit found;
        int strobe_seen;
`ifdef PROG_SEQ_STEP_EN
        while (pc_m != 3) run_once(1'b0);
`endif
        found = 0; strobe_seen = 0;
        SW_LOAD = 1'b0; SW_START = 1'b1;
        for (int c = 0; c < DEB + 20 + 16 * P; c++) begin
            tick();
            if (BUSY === 1'b1 && PC === AW'(3)) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrun_reach_pc3: PC=%0d BUSY=%b expected 3/1", PC, BUSY);
        end
        RST = 1'b1; SW_START = 1'b0;
        tick();
        if ({DEC_EN, ALU_EN, WRI_EN} !== 3'b000) strobe_seen++;
        tick();
        if ({DEC_EN, ALU_EN, WRI_EN} !== 3'b000) strobe_seen++;
        checks++;
        if (PC !== '0 || PLEN !== '0 || BUSY !== 1'b0 || INST !== 8'h00 || FULL !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_state: PC=%0d PLEN=%0d BUSY=%b INST=%02h FULL=%b expected all 0",
                     PC, PLEN, BUSY, INST, FULL);
        end
        RST = 1'b0;
        prog.delete();
        pc_m = 0;
        for (int c = 0; c < 2 * DEB + 10; c++) begin
            tick();
            if ({DEC_EN, ALU_EN, WRI_EN} !== 3'b000 || BUSY !== 1'b0) strobe_seen++;
        end
        checks++;
        if (strobe_seen != 0) begin
            errors++;
            $display("FAIL midrun_no_activity: %0d active cycles expected 0", strobe_seen);
        end
    endtask

    task automatic test_reload();
        load_word(8'($urandom_range(0, 255)), 1'b0);
        load_word(8'($urandom_range(0, 255)), 1'b1);
        run_program(1'b0);
    endtask

    initial begin
        test_reset();
        test_run_empty();
        test_load();
        test_run();
        test_full();
        test_reset_midrun();
        test_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
